// File: rtl/elbert_io_pkg.sv
// Shared definitions for the Elbert V2 board I/O conditioning blocks.
// Provides the debouncer state encoding, the board clock rate and a time-to-cycles helper.
package elbert_io_pkg;

   localparam int CLK_HZ = 12000000;

   typedef enum logic [1:0] {
      STABLE_HIGH  = 2'd0,
      CONFIRM_LOW  = 2'd1,
      STABLE_LOW   = 2'd2,
      CONFIRM_HIGH = 2'd3
   } db_state_e;

   function automatic int ms_to_cycles(input int ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for an asynchronous board input; resets to 1 to match a pulled-up idle pin.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift the raw input one stage deeper every clock.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= {STAGES{1'b1}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces one active-low push-button pin into a clean level plus press, release
// and long-press strobes; a new level is accepted only after a full run of equal samples.
module button_debounce
   import elbert_io_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = ms_to_cycles(10),
   parameter int LONG_CYCLES   = ms_to_cycles(1000)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic PinIn,
   output logic Level,
   output logic Fall,
   output logic Rise,
   output logic LongPress,
   output logic Busy
);

   localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam bit LONG_EN = (LONG_CYCLES > 0);
   localparam int HOLD_W  = LONG_EN ? $clog2(LONG_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_EN ? LONG_CYCLES - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_EN ? LONG_CYCLES : 0);

   db_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              level_q, level_d;
   logic              fall_q, fall_d;
   logic              rise_q, rise_d;
   logic              long_q, long_d;
   logic              busy_q, busy_d;
   logic              pin_sync;
   logic              accept_s;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (Clk),
      .rst (Reset),
      .d   (PinIn),
      .q   (pin_sync)
   );

   // The run in progress is complete when this sample is its STABLE_CYCLES-th.
   assign accept_s = (STABLE_CYCLES == 1) || (cnt_q == CNT_LAST);

   // Next-state, counters and strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      level_d = level_q;
      fall_d  = 1'b0;
      rise_d  = 1'b0;
      long_d  = 1'b0;
      case (state_q)
         STABLE_HIGH: begin
            if (!pin_sync) begin
               state_d = CONFIRM_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         CONFIRM_LOW: begin
            if (pin_sync) begin
               state_d = STABLE_HIGH;
               cnt_d   = CNT_ZERO;
            end else if (accept_s) begin
               state_d = STABLE_LOW;
               cnt_d   = CNT_ZERO;
               level_d = 1'b0;
               fall_d  = 1'b1;
               hold_d  = HOLD_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         STABLE_LOW: begin
            if (pin_sync) begin
               state_d = CONFIRM_HIGH;
               cnt_d   = CNT_ONE;
            end else if (LONG_EN && (hold_q != HOLD_MAX)) begin
               // Saturating at HOLD_MAX gives exactly one LongPress per press.
               hold_d  = hold_q + HOLD_ONE;
               long_d  = (hold_q == HOLD_LAST);
            end else begin
               hold_d  = hold_q;
            end
         end
         CONFIRM_HIGH: begin
            if (!pin_sync) begin
               state_d = STABLE_LOW;
               cnt_d   = CNT_ZERO;
            end else if (accept_s) begin
               state_d = STABLE_HIGH;
               cnt_d   = CNT_ZERO;
               level_d = 1'b1;
               rise_d  = 1'b1;
               hold_d  = HOLD_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_HIGH;
            cnt_d   = CNT_ZERO;
            hold_d  = HOLD_ZERO;
            level_d = 1'b1;
         end
      endcase
      busy_d = (state_d == CONFIRM_LOW) || (state_d == CONFIRM_HIGH);
   end

   // State, counters and registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= STABLE_HIGH;
         cnt_q   <= CNT_ZERO;
         hold_q  <= HOLD_ZERO;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         rise_q  <= 1'b0;
         long_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         rise_q  <= rise_d;
         long_q  <= long_d;
         busy_q  <= busy_d;
      end
   end

   assign Level     = level_q;
   assign Fall      = fall_q;
   assign Rise      = rise_q;
   assign LongPress = long_q;
   assign Busy      = busy_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed timing scenarios plus randomized bounce traffic,
// all checked against a run-length model of the debouncing rules.
module tb_button_debounce;

   localparam int SYNC = 2;
   localparam int STAB = 4;
   localparam int LONG = 10;

   logic clk = 1'b0;
   logic rst;
   logic pin;
   logic level, fall, rise, longp, busy;

   int  vectors     = 0;
   int  miscompares = 0;
   bit  chk_en      = 1'b0;

   int  hist[$];
   int  m_level, m_run, m_hold;
   int  m_fall, m_rise, m_long, m_busy;

   always #5 clk = ~clk;

   button_debounce #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB),
      .LONG_CYCLES   (LONG)
   ) dut (
      .Clk       (clk),
      .Reset     (rst),
      .PinIn     (pin),
      .Level     (level),
      .Fall      (fall),
      .Rise      (rise),
      .LongPress (longp),
      .Busy      (busy)
   );

   task automatic check(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist = {};
      for (int k = 0; k < SYNC; k++) hist.push_back(1);
      m_level = 1; m_run = 0; m_hold = 0;
      m_fall = 0; m_rise = 0; m_long = 0; m_busy = 0;
   endtask

   // s seen at an edge is the pin sampled SYNC edges earlier; a level flips after
   // STAB consecutive opposite samples, and hold counts low samples while settled low.
   task automatic model_edge(input int p);
      int  s;
      bit  settled_low;
      s = hist.pop_front();
      hist.push_back(p);
      m_fall = 0; m_rise = 0; m_long = 0;
      settled_low = (m_level == 0) && (m_run == 0);
      if (s != m_level) begin
         m_run++;
         if (m_run == STAB) begin
            m_level = s;
            m_run   = 0;
            m_hold  = 0;
            if (s == 0) m_fall = 1;
            else        m_rise = 1;
         end
      end else begin
         m_run = 0;
      end
      if (settled_low && s == 0 && m_hold < LONG) begin
         m_hold++;
         if (m_hold == LONG) m_long = 1;
      end
      m_busy = (m_run != 0) ? 1 : 0;
   endtask

   task automatic tick(input logic v);
      pin = v;
      @(posedge clk);
      if (!rst) model_edge(int'(v));
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("level", level, m_level != 0);
         check("fall",  fall,  m_fall  != 0);
         check("rise",  rise,  m_rise  != 0);
         check("long",  longp, m_long  != 0);
         check("busy",  busy,  m_busy  != 0);
      end
   end

   initial begin
      rst = 1'b1;
      pin = 1'b1;
      model_reset();
      #1;
      check("rst_level", level, 1'b1);
      check("rst_fall",  fall,  1'b0);
      check("rst_rise",  rise,  1'b0);
      check("rst_long",  longp, 1'b0);
      check("rst_busy",  busy,  1'b0);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) tick(1'b1);

      // Clean press held into a long press, then release.
      for (int i = 0; i <= 45; i++) begin
         tick(1'b0);
         check("press_fall",  fall,  i == 5);
         check("press_level", level, i < 5);
         check("press_busy",  busy,  i >= 2 && i <= 4);
         check("long_once",   longp, i == 15);
      end
      for (int j = 0; j <= 7; j++) begin
         tick(1'b1);
         check("release_rise",  rise,  j == 5);
         check("release_long",  longp, 1'b0);
         check("release_level", level, j >= 5);
      end
      repeat (3) tick(1'b1);

      // Short press: release five cycles after Fall.
      for (int i = 0; i <= 17; i++) begin
         tick(i < 10 ? 1'b0 : 1'b1);
         check("short_fall", fall,  i == 5);
         check("short_rise", rise,  i == 15);
         check("short_long", longp, 1'b0);
      end
      repeat (3) tick(1'b1);

      // Two-cycle glitch high while held low delays LongPress by three edges.
      for (int i = 0; i <= 22; i++) begin
         tick((i == 10 || i == 11) ? 1'b1 : 1'b0);
         check("glitch_long",  longp, i == 18);
         check("glitch_rise",  rise,  1'b0);
         check("glitch_level", level, i < 5);
      end
      repeat (8) tick(1'b1);
      check("glitch_end_level", level, 1'b1);

      // Bounce: three low samples never reach acceptance.
      for (int i = 0; i < 3; i++) tick(1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1);
         check("bounce_fall",  fall,  1'b0);
         check("bounce_level", level, 1'b1);
      end
      check("bounce_busy", busy, 1'b0);

      // Asynchronous reset in the middle of a confirmation.
      for (int i = 0; i < 3; i++) tick(1'b0);
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      model_reset();
      #1;
      check("async_level", level, 1'b1);
      check("async_busy",  busy,  1'b0);
      check("async_fall",  fall,  1'b0);
      check("async_rise",  rise,  1'b0);
      check("async_long",  longp, 1'b0);
      repeat (2) tick(1'b1);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1);
         check("post_rst_fall", fall,  1'b0);
         check("post_rst_rise", rise,  1'b0);
         check("post_rst_long", longp, 1'b0);
      end

      // Asynchronous reset in the middle of a hold.
      for (int i = 0; i < 9; i++) tick(1'b0);
      check("mid_hold_level", level, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      check("hold_rst_level", level, 1'b1);
      check("hold_rst_busy",  busy,  1'b0);
      repeat (2) tick(1'b1);
      rst = 1'b0;
      repeat (5) tick(1'b1);

      // Randomized runs: mostly short bounces, sometimes long holds.
      for (int n = 0; n < 400; n++) begin
         logic v;
         int   len;
         v   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 25))
                                           : int'($urandom_range(1, 5));
         repeat (len) tick(v);
      end
      repeat (30) tick(1'b1);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
